// File: rtl/pipelined_weight_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_weight_multiplier
//
// Synaptic multiplier sitting between the spike/neuron controller (SNC) and the
// serial adder (SADD) of a PE. Data-type NoC packets are multiplied by a
// per-source weight held in an internal table. The product is delivered to
// SADD together with the source index. All other packet types are consumed
// and counted as drops.
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   SNC_MUL_valid            input packet valid
//   SNC_MUL_packet           {type, dest, source, seq, payload} (MSB..LSB)
//   SNC_MUL_ready            packet accepted this cycle (combinational from
//                            MUL_SADD_ready)
//   MUL_SADD_ready           SADD accepts the output this cycle
//   MUL_SADD_valid           output valid
//   MUL_SADD_inputNumber     source index of the packet
//   MUL_SADD_partialProduct  full-width payload x weight
//   CFG_weight_we            weight table write enable (ignores stall/reset)
//   CFG_weight_addr          weight table write address
//   CFG_weight_data          weight value to write
//   MUL_dropCount            saturating count of dropped non-data packets
//
// PIPE_STAGES is the accept-to-output register count. The legal range is 2..6.
// PAYLOAD_WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module pipelined_weight_multiplier #(
  parameter int                    NETWORK_SIZE   = 256,
  parameter int                    PAYLOAD_WIDTH  = 22,
  parameter int                    SEQ_WIDTH      = 4,
  parameter int                    TYPE_WIDTH     = 2,
  parameter logic [TYPE_WIDTH-1:0] TYPE_DATA      = 2'b01,
  parameter int                    PIPE_STAGES    = 3,
  parameter bit                    SIGNED         = 1'b1,
  parameter int                    DROP_CNT_WIDTH = 16,
  localparam int ID_W        = $clog2(NETWORK_SIZE),
  localparam int PACKET_SIZE = PAYLOAD_WIDTH + SEQ_WIDTH + 2 * ID_W + TYPE_WIDTH,
  localparam int PROD_W      = 2 * PAYLOAD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SNC_MUL_valid,
  input  logic [PACKET_SIZE-1:0]    SNC_MUL_packet,
  output logic                      SNC_MUL_ready,
  input  logic                      MUL_SADD_ready,
  output logic                      MUL_SADD_valid,
  output logic [ID_W-1:0]           MUL_SADD_inputNumber,
  output logic [PROD_W-1:0]         MUL_SADD_partialProduct,
  input  logic                      CFG_weight_we,
  input  logic [ID_W-1:0]           CFG_weight_addr,
  input  logic [PAYLOAD_WIDTH-1:0]  CFG_weight_data,
  output logic [DROP_CNT_WIDTH-1:0] MUL_dropCount
);

  localparam int SEQ_LSB  = PAYLOAD_WIDTH;
  localparam int SRC_LSB  = SEQ_LSB + SEQ_WIDTH;
  localparam int DST_LSB  = SRC_LSB + ID_W;
  localparam int TYPE_LSB = DST_LSB + ID_W;

  // The weight is split into a low half and a high half. The two partial
  // products can then be registered separately before they are summed.
  localparam int LO_W = PAYLOAD_WIDTH / 2;
  localparam int HI_W = PAYLOAD_WIDTH - LO_W;

  // ---------------------------------------------------------------------------
  // Packet field extraction
  // ---------------------------------------------------------------------------
  logic [PAYLOAD_WIDTH-1:0] pkt_payload;
  logic [SEQ_WIDTH-1:0]     pkt_seq;
  logic [ID_W-1:0]          pkt_src;
  logic [ID_W-1:0]          pkt_dest;
  logic [TYPE_WIDTH-1:0]    pkt_type;

  assign pkt_payload = SNC_MUL_packet[PAYLOAD_WIDTH-1:0];
  assign pkt_seq     = SNC_MUL_packet[SRC_LSB-1:SEQ_LSB];
  assign pkt_src     = SNC_MUL_packet[DST_LSB-1:SRC_LSB];
  assign pkt_dest    = SNC_MUL_packet[TYPE_LSB-1:DST_LSB];
  assign pkt_type    = SNC_MUL_packet[PACKET_SIZE-1:TYPE_LSB];

  // Sequence and destination are routing information that has no use here.
  logic unused_fields;
  assign unused_fields = ^{pkt_seq, pkt_dest};

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic              out_valid;
  logic [ID_W-1:0]   out_src;
  logic [PROD_W-1:0] out_prod;

  logic adv;
  logic accept;
  logic is_data;

  // The pipeline has no skid buffer. Everything freezes while the output
  // holds a product that SADD has not taken yet.
  assign adv           = !out_valid || MUL_SADD_ready;
  assign SNC_MUL_ready = adv;
  assign accept        = SNC_MUL_valid && adv;
  assign is_data       = (pkt_type == TYPE_DATA);

  assign MUL_SADD_valid          = out_valid;
  assign MUL_SADD_inputNumber    = out_src;
  assign MUL_SADD_partialProduct = out_prod;

  // ---------------------------------------------------------------------------
  // Weight table (not reset; writes are never gated by stall or reset)
  // ---------------------------------------------------------------------------
  logic [PAYLOAD_WIDTH-1:0] weight_mem [NETWORK_SIZE];

  always_ff @(posedge clk) begin
    if (CFG_weight_we) begin
      weight_mem[CFG_weight_addr] <= CFG_weight_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture payload/source and read the weight
  // ---------------------------------------------------------------------------
  logic                     s1_valid;
  logic [ID_W-1:0]          s1_src;
  logic [PAYLOAD_WIDTH-1:0] s1_payload;
  logic [PAYLOAD_WIDTH-1:0] s1_weight;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_src     <= '0;
      s1_payload <= '0;
    end else if (adv) begin
      s1_valid <= accept && is_data;
      if (accept) begin
        s1_src     <= pkt_src;
        s1_payload <= pkt_payload;
      end
    end
  end

  // The read register is kept free of reset so the table maps onto block RAM.
  // A write to the same address on the same edge is not visible yet: this is
  // read-before-write behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_weight <= weight_mem[pkt_src];
    end
  end

  // ---------------------------------------------------------------------------
  // Partial products from stage 1 operands
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] op_a;
  logic [PROD_W-1:0] op_b_lo;
  logic [PROD_W-1:0] op_b_hi;
  logic [PROD_W-1:0] pp_lo;
  logic [PROD_W-1:0] pp_hi;

  // The weight is decomposed as weight = hi * 2^LO_W + lo. The low part is
  // always unsigned and the high part carries the sign in signed mode. The
  // operands are extended to the full product width, so the modulo-2^PROD_W
  // products below are exact.
  always_comb begin
    op_a    = {{PAYLOAD_WIDTH{SIGNED && s1_payload[PAYLOAD_WIDTH-1]}}, s1_payload};
    op_b_lo = {{(PROD_W - LO_W){1'b0}}, s1_weight[LO_W-1:0]};
    op_b_hi = {{(PROD_W - HI_W){SIGNED && s1_weight[PAYLOAD_WIDTH-1]}},
               s1_weight[PAYLOAD_WIDTH-1:LO_W]};
    pp_lo   = op_a * op_b_lo;
    pp_hi   = (op_a * op_b_hi) << LO_W;
  end

  // ---------------------------------------------------------------------------
  // Stages 2..PIPE_STAGES
  // ---------------------------------------------------------------------------
  generate
    if (PIPE_STAGES == 2) begin : g_two_stage
      // With only two stages, the summation shares the stage 2 cycle with the
      // partial products.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_src   <= '0;
          out_prod  <= '0;
        end else if (adv) begin
          out_valid <= s1_valid;
          out_src   <= s1_src;
          out_prod  <= pp_lo + pp_hi;
        end
      end
    end else begin : g_multi_stage
      logic              s2_valid;
      logic [ID_W-1:0]   s2_src;
      logic [PROD_W-1:0] s2_pp_lo;
      logic [PROD_W-1:0] s2_pp_hi;

      logic              d_valid [3:PIPE_STAGES];
      logic [ID_W-1:0]   d_src   [3:PIPE_STAGES];
      logic [PROD_W-1:0] d_prod  [3:PIPE_STAGES];

      // Stage 2 registers the partial products and stage 3 registers their
      // sum. Any further stages are plain delay registers, which synthesis is
      // free to retime back into the multiplier.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_src   <= '0;
          s2_pp_lo <= '0;
          s2_pp_hi <= '0;
          for (int s = 3; s <= PIPE_STAGES; s++) begin
            d_valid[s] <= 1'b0;
            d_src[s]   <= '0;
            d_prod[s]  <= '0;
          end
        end else if (adv) begin
          s2_valid   <= s1_valid;
          s2_src     <= s1_src;
          s2_pp_lo   <= pp_lo;
          s2_pp_hi   <= pp_hi;
          d_valid[3] <= s2_valid;
          d_src[3]   <= s2_src;
          d_prod[3]  <= s2_pp_lo + s2_pp_hi;
          for (int s = 4; s <= PIPE_STAGES; s++) begin
            d_valid[s] <= d_valid[s-1];
            d_src[s]   <= d_src[s-1];
            d_prod[s]  <= d_prod[s-1];
          end
        end
      end

      assign out_valid = d_valid[PIPE_STAGES];
      assign out_src   = d_src[PIPE_STAGES];
      assign out_prod  = d_prod[PIPE_STAGES];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Dropped-packet counter (saturating)
  // ---------------------------------------------------------------------------
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && !is_data && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign MUL_dropCount = drop_cnt;

endmodule

// File: tb/tb_pipelined_weight_multiplier.sv
// -----------------------------------------------------------------------------
// tb_pipelined_weight_multiplier
//
// Uses two instances of the multiplier.
//   dut   : defaults (3 stages, signed, 16-bit drop counter)
//   dut_u : 2 stages, unsigned, 4-bit drop counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipelined_weight_multiplier;

  localparam int W    = 22;
  localparam int ID_W = 8;
  localparam int PKT  = 22 + 4 + 2 * 8 + 2;
  localparam int PW   = 44;
  localparam int NVEC = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // signals of the signed, three-stage instance
  logic            snc_valid;
  logic [PKT-1:0]  snc_packet;
  logic            snc_ready;
  logic            sadd_ready;
  logic            mul_valid;
  logic [ID_W-1:0] mul_src;
  logic [PW-1:0]   mul_prod;
  logic            cfg_we;
  logic [ID_W-1:0] cfg_addr;
  logic [W-1:0]    cfg_data;
  logic [15:0]     drop_cnt;

  // signals of the unsigned, two-stage instance
  logic            u_valid;
  logic [PKT-1:0]  u_packet;
  logic            u_ready;
  logic            u_sadd_ready;
  logic            u_out_valid;
  logic [ID_W-1:0] u_out_src;
  logic [PW-1:0]   u_out_prod;
  logic            u_we;
  logic [ID_W-1:0] u_addr;
  logic [W-1:0]    u_data;
  logic [3:0]      u_drop;

  pipelined_weight_multiplier #(
    .PIPE_STAGES(3), .SIGNED(1'b1), .DROP_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .SNC_MUL_valid(snc_valid), .SNC_MUL_packet(snc_packet), .SNC_MUL_ready(snc_ready),
    .MUL_SADD_ready(sadd_ready), .MUL_SADD_valid(mul_valid),
    .MUL_SADD_inputNumber(mul_src), .MUL_SADD_partialProduct(mul_prod),
    .CFG_weight_we(cfg_we), .CFG_weight_addr(cfg_addr), .CFG_weight_data(cfg_data),
    .MUL_dropCount(drop_cnt)
  );

  pipelined_weight_multiplier #(
    .PIPE_STAGES(2), .SIGNED(1'b0), .DROP_CNT_WIDTH(4)
  ) dut_u (
    .clk(clk), .rst(rst),
    .SNC_MUL_valid(u_valid), .SNC_MUL_packet(u_packet), .SNC_MUL_ready(u_ready),
    .MUL_SADD_ready(u_sadd_ready), .MUL_SADD_valid(u_out_valid),
    .MUL_SADD_inputNumber(u_out_src), .MUL_SADD_partialProduct(u_out_prod),
    .CFG_weight_we(u_we), .CFG_weight_addr(u_addr), .CFG_weight_data(u_data),
    .MUL_dropCount(u_drop)
  );

  typedef struct {
    logic [1:0]  ptype;
    logic [7:0]  src;
    logic [21:0] payload;
    logic        exp_out;
    logic [43:0] exp_prod;
  } vec_t;

  typedef struct {
    logic [7:0]  src;
    logic [43:0] prod;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t exp_q [$];
  exp_t e;

  int errors = 0;
  int checks = 0;
  int exp_drops;
  int sent;
  int recv;
  int stale;
  logic acc;
  logic stall;
  logic [ID_W-1:0] held_src;
  logic [PW-1:0]   held_prod;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [PKT-1:0] mk_packet(input logic [1:0] t, input logic [7:0] src,
                                               input logic [21:0] pay);
    return {t, 8'hA5, src, 4'h3, pay};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_weight(input logic [7:0] addr, input logic [21:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Drives one packet for exactly one edge. The caller guarantees ready is
  // high at that edge.
  task automatic apply_stimulus(input logic [1:0] t, input logic [7:0] src,
                                input logic [21:0] pay);
    snc_valid  = 1'b1;
    snc_packet = mk_packet(t, src, pay);
    tick();
    snc_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b01, 8'd5, 22'd7,       1'b1, 44'd21};
    vecs[1] = '{2'b01, 8'd0, 22'h200000,  1'b1, 44'h400_0000_0000};
    vecs[2] = '{2'b00, 8'd5, 22'd1,       1'b0, 44'd0};
    vecs[3] = '{2'b01, 8'd1, 22'd5,       1'b1, 44'hFFF_FFFF_FFF1};
    vecs[4] = '{2'b10, 8'd2, 22'd9,       1'b0, 44'd0};
    vecs[5] = '{2'b01, 8'd2, 22'h3FFFFF,  1'b1, 44'hFFF_FFFF_FF9C};
    vecs[6] = '{2'b11, 8'd3, 22'd4,       1'b0, 44'd0};
    vecs[7] = '{2'b01, 8'd3, 22'h1FFFFF,  1'b1, 44'h3FF_FFC0_0001};

    rst = 1'b1;
    snc_valid = 1'b0; snc_packet = '0; sadd_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    u_valid = 1'b0; u_packet = '0; u_sadd_ready = 1'b1;
    u_we = 1'b0; u_addr = '0; u_data = '0;
    repeat (2) tick();

    // reset state
    check_output("rst_valid", mul_valid, 0);
    check_output("rst_src", mul_src, 0);
    check_output("rst_prod", mul_prod, 0);
    check_output("rst_drop", drop_cnt, 0);
    check_output("rst_ready", snc_ready, 1);
    check_output("rst_u_drop", u_drop, 0);
    rst = 1'b0;

    write_weight(8'd5, 22'd3);
    write_weight(8'd0, 22'h200000);
    write_weight(8'd1, 22'h3FFFFD);
    write_weight(8'd2, 22'd100);
    write_weight(8'd3, 22'h1FFFFF);

    // basic multiply and latency: accepted at edge k, valid after edge k+2
    apply_stimulus(2'b01, 8'd5, 22'd7);
    check_output("lat_k_valid", mul_valid, 0);
    tick();
    check_output("lat_k1_valid", mul_valid, 0);
    tick();
    check_output("lat_k2_valid", mul_valid, 1);
    check_output("lat_k2_src", mul_src, 5);
    check_output("lat_k2_prod", mul_prod, 21);
    tick();

    // table stream, back-to-back with mixed packet types
    exp_q.delete();
    exp_drops = 0;
    for (int c = 0; c < NVEC + 5; c++) begin
      if (c < NVEC) begin
        snc_valid  = 1'b1;
        snc_packet = mk_packet(vecs[c].ptype, vecs[c].src, vecs[c].payload);
        if (vecs[c].exp_out) exp_q.push_back('{vecs[c].src, vecs[c].exp_prod});
        else exp_drops++;
      end else begin
        snc_valid = 1'b0;
      end
      tick();
      if (mul_valid) begin
        if (exp_q.size() == 0) begin
          check_output("tbl_extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("tbl_src", mul_src, e.src);
          check_output("tbl_prod", mul_prod, e.prod);
        end
      end
    end
    check_output("tbl_missing", exp_q.size(), 0);
    check_output("tbl_drop_count", drop_cnt, exp_drops);

    // write/read collision on weight[9]
    write_weight(8'd9, 22'd4);
    snc_valid  = 1'b1;
    snc_packet = mk_packet(2'b01, 8'd9, 22'd10);
    cfg_we = 1'b1; cfg_addr = 8'd9; cfg_data = 22'd6;
    tick();
    cfg_we = 1'b0;
    tick();
    snc_valid = 1'b0;
    tick();
    check_output("col_old_valid", mul_valid, 1);
    check_output("col_old_prod", mul_prod, 40);
    tick();
    check_output("col_new_valid", mul_valid, 1);
    check_output("col_new_prod", mul_prod, 60);
    tick();

    // stream with random backpressure
    for (int i = 0; i < 16; i++) write_weight(8'(i), 22'(i));
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
      sadd_ready = ($urandom_range(0, 1) == 1);
      if (sent < 16) begin
        snc_valid  = 1'b1;
        snc_packet = mk_packet(2'b01, 8'(sent), 22'd2);
      end else begin
        snc_valid = 1'b0;
      end
      #1;
      acc   = snc_valid && snc_ready;
      stall = mul_valid && !sadd_ready;
      if (stall) begin
        held_src  = mul_src;
        held_prod = mul_prod;
        check_output("bp_stall_ready", snc_ready, 0);
      end
      if (mul_valid && sadd_ready) begin
        check_output("bp_src", mul_src, recv);
        check_output("bp_prod", mul_prod, 2 * recv);
        recv++;
      end
      tick();
      if (acc) sent++;
      if (stall) begin
        check_output("bp_hold_valid", mul_valid, 1);
        check_output("bp_hold_src", mul_src, held_src);
        check_output("bp_hold_prod", mul_prod, held_prod);
      end
    end
    check_output("bp_received", recv, 16);
    snc_valid  = 1'b0;
    sadd_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      tick();
      stale += int'(mul_valid);
    end
    check_output("bp_no_dup", stale, 0);

    // reset with three products in flight and the output stalled
    write_weight(8'd7, 22'd5);
    sadd_ready = 1'b0;
    apply_stimulus(2'b01, 8'd1, 22'd1);
    apply_stimulus(2'b01, 8'd2, 22'd1);
    apply_stimulus(2'b01, 8'd3, 22'd1);
    check_output("mf_stalled_valid", mul_valid, 1);
    check_output("mf_stalled_ready", snc_ready, 0);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_addr = 8'd7; cfg_data = 22'd11;
    tick();
    cfg_we = 1'b0;
    check_output("mf_rst_valid", mul_valid, 0);
    check_output("mf_rst_prod", mul_prod, 0);
    check_output("mf_rst_drop", drop_cnt, 0);
    check_output("mf_rst_ready", snc_ready, 1);
    rst = 1'b0;
    sadd_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      tick();
      stale += int'(mul_valid);
    end
    check_output("mf_no_stale", stale, 0);
    apply_stimulus(2'b01, 8'd7, 22'd3);
    tick();
    tick();
    check_output("mf_wr_on_rst_valid", mul_valid, 1);
    check_output("mf_wr_on_rst_prod", mul_prod, 33);
    tick();

    // unsigned, two-stage instance
    u_we = 1'b1; u_addr = 8'd0; u_data = 22'h3FFFFF;
    tick();
    u_we = 1'b0;
    u_valid  = 1'b1;
    u_packet = mk_packet(2'b01, 8'd0, 22'h3FFFFF);
    tick();
    u_packet = mk_packet(2'b01, 8'd0, 22'd2);
    check_output("u_lat_k_valid", u_out_valid, 0);
    tick();
    u_valid = 1'b0;
    check_output("u_max_valid", u_out_valid, 1);
    check_output("u_max_prod", u_out_prod, 44'hFFF_FF80_0001);
    tick();
    check_output("u_small_valid", u_out_valid, 1);
    check_output("u_small_prod", u_out_prod, 44'h7F_FFFE);
    tick();

    // drop counter saturation on the 4-bit instance: 20 drops
    u_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      u_packet = mk_packet((i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b10 : 2'b11),
                           8'(i), 22'd1);
      tick();
      if (i == 13) check_output("u_drop_14", u_drop, 14);
      if (i == 14) check_output("u_drop_15", u_drop, 15);
    end
    u_valid = 1'b0;
    check_output("u_drop_sat", u_drop, 15);
    tick();
    check_output("u_drop_no_output", u_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_weight_multiplier.md
# pipelined_weight_multiplier

Parametrised, pipelined synaptic multiplier for the PE datapath, between the spike/neuron controller (SNC) and the serial adder (SADD). It accepts NoC packets over a valid/ready handshake, filters them by packet type, and looks up a per-source synaptic weight in an internal configurable weight table. It multiplies the packet payload by that weight in a stall-able multi-stage pipeline and hands the full-width product plus the source index to SADD.

## Interface
- NETWORK_SIZE, 256: number of PEs; sets source/dest field width and weight-table depth.
- PAYLOAD_WIDTH, 22: payload and weight width.
- SEQ_WIDTH, 4: sequence field width.
- TYPE_WIDTH, 2: packet type field width.
- TYPE_DATA, 2'b01: type code that is multiplied; every other code is dropped.
- PIPE_STAGES, 3: input-to-output latency in cycles; legal range 2..6.
- SIGNED, 1: 1 = two's-complement operands and product; 0 = unsigned.
- DROP_CNT_WIDTH, 16: width of the dropped-packet counter.
- Derived widths:
  - ID_W = $clog2(NETWORK_SIZE).
  - Packet field order, LSB first: payload, seq, source, dest, type.
  - PACKET_SIZE = PAYLOAD_WIDTH + SEQ_WIDTH + 2·ID_W + TYPE_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- SNC_MUL_valid  in  1  input packet valid.
- SNC_MUL_packet  in  PACKET_SIZE  input packet.
- SNC_MUL_ready  out  1  block accepts the packet this cycle.
- MUL_SADD_ready  in  1  SADD accepts the output this cycle.
- MUL_SADD_valid  out  1  output valid.
- MUL_SADD_inputNumber  out  ID_W  source field of the packet.
- MUL_SADD_partialProduct  out  2·PAYLOAD_WIDTH  payload × weight.
- CFG_weight_we  in  1  weight-table write enable.
- CFG_weight_addr  in  ID_W  weight-table write address (source index).
- CFG_weight_data  in  PAYLOAD_WIDTH  weight to write.
- MUL_dropCount  out  DROP_CNT_WIDTH  saturating count of dropped non-data packets.

## Operation
- **Handshake:** a transfer occurs on a rising edge where valid && ready. Producers must hold the packet and valid stable until the transfer.
- **Advance signal:** adv = !MUL_SADD_valid || MUL_SADD_ready.
  - SNC_MUL_ready = adv. This is a deliberate combinational path from MUL_SADD_ready.
  - The whole pipeline moves only when adv = 1.
  - While stalled, every stage register, including MUL_SADD_*, holds its value.
- **Stage 1 (capture):** on an accepted packet, register the payload and source, and perform a synchronous read of weight[source].
- **Type filter:** an accepted packet whose type ≠ TYPE_DATA is consumed (ready still asserted) but enters the pipeline as a bubble. It increments MUL_dropCount, which saturates at all-ones.
- **Stages 2..PIPE_STAGES:** the multiply is retimed across these stages. Each stage carries a valid bit and the source index alongside the data.
- **Product:** full 2·PAYLOAD_WIDTH width, no truncation and no overflow possible.
  - SIGNED = 1: both operands are sign-extended.
  - SIGNED = 0: both operands are zero-extended.
- **Weight table:** NETWORK_SIZE × PAYLOAD_WIDTH storage.
  - Written on any edge with CFG_weight_we = 1, independent of stall.
  - A write and a stage-1 read of the same address on the same edge returns the old weight (read-before-write). The new weight applies from the next accepted packet.
- **Ordering:** outputs appear strictly in acceptance order, with no reordering and no duplication.

## Timing
- **Reset values:**
  - MUL_SADD_valid = 0, MUL_SADD_inputNumber = 0, MUL_SADD_partialProduct = 0, MUL_dropCount = 0.
  - All stage valid bits = 0.
  - SNC_MUL_ready = 1 during and after reset, since the pipeline is empty.
  - Weight table contents are not cleared by reset and must be loaded over CFG.
- **Latency:** a data packet accepted on edge k makes MUL_SADD_valid = 1 after edge k+PIPE_STAGES−1. With PIPE_STAGES = 3, it is presented in the cycle following edge k+2.
  - Stalls add exactly one cycle per stalled cycle.
- **Throughput:** one packet per cycle while MUL_SADD_ready = 1.
- **Back-to-back with stall:** while MUL_SADD_valid && !MUL_SADD_ready, ready = 0 and nothing is lost. Bubbles are not compressed while stalled.
- **Reset mid-operation:** in-flight products are discarded and the drop counter clears. Weight writes on the reset edge are still performed.
- **Simultaneous events:** drop increment and saturation, weight write, and pipeline advance are all independent and may occur on the same edge.

## Test plan
- **Basic multiply:** PIPE_STAGES = 3, SIGNED = 1. Load weight[5] = 3. Send a type-01 packet, source = 5, payload = 7 → output valid 3 cycles after acceptance with inputNumber = 5 and product = 21.
- **Signed extremes:** weight[0] = −2^21, payload = −2^21 → product = 2^42 (0x400_0000_0000). With SIGNED = 0 and payload = weight = 0x3FFFFF → product = 0x0F_FFFF_8000_01.
- **Stream with backpressure:** 16 back-to-back packets (sources 0..15, weight[i] = i, payload = 2) with MUL_SADD_ready toggled randomly → 16 outputs in order, products 0,2,…,30, none lost or duplicated.
- **Type filter:** interleave types 00/10/11 with 01 → only the type-01 packets are output. MUL_dropCount equals the number dropped. With DROP_CNT_WIDTH = 4 and 20 drops → counter holds at 15.
- **Write/read collision:** weight[9] = 4, then on the same edge accept a source-9 payload-10 packet and write weight[9] = 6 → product 40. The next source-9 payload-10 packet gives 60.
- **Reset mid-flight:** assert rst with 3 products in flight and MUL_SADD_ready = 0 → the next cycle shows valid = 0, product = 0, dropCount = 0, ready = 1. No stale output appears afterwards.
